// File: rtl/screen_arbiter.sv
// Screen RAM port arbiter: raster fetch has priority over CPU accesses; fetched words are
// buffered one deep and shifted out LSB-first as one pixel per pixel_en strobe.
module screen_arbiter #(
  parameter int unsigned SCREEN_WORDS = 8192,
  parameter int unsigned ADDR_W       = 13
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [15:0]       cpu_wdata,
  output logic              cpu_ready,
  output logic [15:0]       cpu_rdata,
  output logic              cpu_rvalid,
  input  logic              frame_start,
  input  logic              pixel_en,
  output logic              pixel,
  output logic              underrun,
  output logic              ram_load,
  output logic [15:0]       ram_address,
  output logic [15:0]       ram_in,
  input  logic [15:0]       ram_out
);

  localparam int unsigned    FaW      = ADDR_W + 1;
  localparam logic [FaW-1:0] FetchEnd = FaW'(SCREEN_WORDS);

  logic [FaW-1:0]    fetch_addr_q, fetch_addr_d;
  logic              frame_active_q, frame_active_d;
  logic              buf_valid_q, buf_valid_d;
  logic [15:0]       buf_q, buf_d;
  logic              disp_inflight_q, disp_inflight_d;
  logic              cpu_inflight_q, cpu_inflight_d;
  logic [15:0]       rdata_q, rdata_d;
  logic [3:0]        bit_cnt_q, bit_cnt_d;
  logic [14:0]       shreg_q, shreg_d;
  logic              pixel_q, pixel_d;
  logic              underrun_q, underrun_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [15:0]       wdata_q, wdata_d;

  logic              fetch_need;
  logic              cpu_issue;
  logic              words_left;
  logic              last_word;
  logic [15:0]       word;

  always_comb begin
    fetch_need = frame_active_q & ~buf_valid_q & ~disp_inflight_q & (fetch_addr_q < FetchEnd);
    cpu_issue  = cpu_req & ~fetch_need & ~reset;
  end

  // Port is driven combinationally; the RAM samples it on the next edge.
  assign cpu_ready   = cpu_issue;
  assign ram_load    = cpu_issue & cpu_we;
  assign ram_in      = ram_load ? cpu_wdata : wdata_q;
  assign ram_address = 16'(fetch_need ? fetch_addr_q[ADDR_W-1:0] :
                           cpu_issue  ? cpu_addr : addr_q);
  assign cpu_rvalid  = cpu_inflight_q;
  assign cpu_rdata   = cpu_inflight_q ? ram_out : rdata_q;
  assign pixel       = pixel_q;
  assign underrun    = underrun_q;

  always_comb begin
    fetch_addr_d    = fetch_addr_q;
    frame_active_d  = frame_active_q;
    buf_valid_d     = buf_valid_q;
    buf_d           = buf_q;
    rdata_d         = rdata_q;
    bit_cnt_d       = bit_cnt_q;
    shreg_d         = shreg_q;
    pixel_d         = pixel_q;
    underrun_d      = underrun_q;
    addr_d          = addr_q;
    wdata_d         = wdata_q;
    word            = 16'h0000;
    words_left      = frame_active_q & ((fetch_addr_q < FetchEnd) | disp_inflight_q);
    last_word       = buf_valid_q & ~disp_inflight_q & (fetch_addr_q == FetchEnd);
    disp_inflight_d = fetch_need;
    cpu_inflight_d  = cpu_issue & ~cpu_we;

    if (fetch_need) begin
      fetch_addr_d = fetch_addr_q + 1'b1;
    end
    if (fetch_need || cpu_issue) begin
      addr_d = ram_address[ADDR_W-1:0];
    end
    if (ram_load) begin
      wdata_d = cpu_wdata;
    end
    if (cpu_inflight_q) begin
      rdata_d = ram_out;
    end

    if (pixel_en) begin
      bit_cnt_d = bit_cnt_q + 4'd1;
      if (bit_cnt_q == 4'd0) begin
        word        = buf_valid_q ? buf_q : 16'h0000;
        pixel_d     = word[0];
        shreg_d     = word[15:1];
        buf_valid_d = 1'b0;
        if (!buf_valid_q && words_left) begin
          underrun_d = 1'b1;
        end
        if (last_word) begin
          frame_active_d = 1'b0;
        end
      end else begin
        pixel_d = shreg_q[0];
        shreg_d = shreg_q >> 1;
      end
    end

    // A return in the same cycle as a consume still refills the buffer afterwards.
    if (disp_inflight_q) begin
      buf_valid_d = 1'b1;
      buf_d       = ram_out;
    end

    // Restart drops any in-flight display word; CPU reads complete regardless.
    if (frame_start) begin
      frame_active_d  = 1'b1;
      fetch_addr_d    = '0;
      buf_valid_d     = 1'b0;
      bit_cnt_d       = 4'd0;
      underrun_d      = 1'b0;
      disp_inflight_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fetch_addr_q    <= '0;
      frame_active_q  <= 1'b0;
      buf_valid_q     <= 1'b0;
      buf_q           <= 16'h0000;
      disp_inflight_q <= 1'b0;
      cpu_inflight_q  <= 1'b0;
      rdata_q         <= 16'h0000;
      bit_cnt_q       <= 4'd0;
      shreg_q         <= 15'h0000;
      pixel_q         <= 1'b0;
      underrun_q      <= 1'b0;
      addr_q          <= '0;
      wdata_q         <= 16'h0000;
    end else begin
      fetch_addr_q    <= fetch_addr_d;
      frame_active_q  <= frame_active_d;
      buf_valid_q     <= buf_valid_d;
      buf_q           <= buf_d;
      disp_inflight_q <= disp_inflight_d;
      cpu_inflight_q  <= cpu_inflight_d;
      rdata_q         <= rdata_d;
      bit_cnt_q       <= bit_cnt_d;
      shreg_q         <= shreg_d;
      pixel_q         <= pixel_d;
      underrun_q      <= underrun_d;
      addr_q          <= addr_d;
      wdata_q         <= wdata_d;
    end
  end

endmodule

// File: tb/tb_screen_arbiter.sv
// Randomised bench for screen_arbiter: a RAM model plus a frame-level pixel/CPU reference.
module tb_screen_arbiter;

  localparam int unsigned SW = 64;

  logic        clk = 1'b0;
  logic        reset;
  logic        cpu_req;
  logic        cpu_we;
  logic [12:0] cpu_addr;
  logic [15:0] cpu_wdata;
  logic        cpu_ready;
  logic [15:0] cpu_rdata;
  logic        cpu_rvalid;
  logic        frame_start;
  logic        pixel_en;
  logic        pixel;
  logic        underrun;
  logic        ram_load;
  logic [15:0] ram_address;
  logic [15:0] ram_in;
  logic [15:0] ram_out;

  always #5 clk = ~clk;

  screen_arbiter #(
    .SCREEN_WORDS(SW),
    .ADDR_W      (13)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .cpu_req    (cpu_req),
    .cpu_we     (cpu_we),
    .cpu_addr   (cpu_addr),
    .cpu_wdata  (cpu_wdata),
    .cpu_ready  (cpu_ready),
    .cpu_rdata  (cpu_rdata),
    .cpu_rvalid (cpu_rvalid),
    .frame_start(frame_start),
    .pixel_en   (pixel_en),
    .pixel      (pixel),
    .underrun   (underrun),
    .ram_load   (ram_load),
    .ram_address(ram_address),
    .ram_in     (ram_in),
    .ram_out    (ram_out)
  );

  // Screen RAM: synchronous write, registered read.
  logic [15:0] mem [0:8191];
  always @(posedge clk) begin
    if (ram_load) mem[ram_address[12:0]] <= ram_in;
    else          ram_out <= mem[ram_address[12:0]];
  end

  int unsigned n_vec;
  int unsigned n_err;

  // Reference state: pixel k of a frame is bit k%16 of word k/16.
  logic        frame_on;
  logic        pix_model;
  logic        und_model;
  logic        prev_rd;
  logic        accepted;
  logic        starve;
  logic [15:0] exp_rd;
  logic [15:0] last_rd;
  int unsigned k;
  int unsigned wait_cnt;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic monitor();
    logic [15:0] w;
    if (reset) begin
      check_eq("rst_cpu_ready", 32'(cpu_ready), 0);
      check_eq("rst_cpu_rvalid", 32'(cpu_rvalid), 0);
      check_eq("rst_cpu_rdata", 32'(cpu_rdata), 0);
      check_eq("rst_pixel", 32'(pixel), 0);
      check_eq("rst_underrun", 32'(underrun), 0);
      check_eq("rst_ram_load", 32'(ram_load), 0);
      check_eq("rst_ram_address", 32'(ram_address), 0);
      check_eq("rst_ram_in", 32'(ram_in), 0);
      frame_on  = 1'b0;
      k         = 0;
      wait_cnt  = 0;
      prev_rd   = 1'b0;
      last_rd   = 16'h0000;
      pix_model = 1'b0;
      und_model = 1'b0;
      accepted  = 1'b0;
      return;
    end
    check_eq("pixel", 32'(pixel), 32'(pix_model));
    check_eq("underrun", 32'(underrun), 32'(und_model));
    check_eq("cpu_rvalid", 32'(cpu_rvalid), 32'(prev_rd));
    if (prev_rd) begin
      check_eq("cpu_rdata", 32'(cpu_rdata), 32'(exp_rd));
      last_rd = exp_rd;
    end else begin
      check_eq("cpu_rdata_hold", 32'(cpu_rdata), 32'(last_rd));
    end
    check_eq("ram_load", 32'(ram_load), 32'(cpu_ready & cpu_we));
    if (cpu_ready) begin
      check_eq("ready_without_req", 32'(cpu_req), 1);
      check_eq("ram_address_cpu", 32'(ram_address), 32'(cpu_addr));
      if (cpu_we) check_eq("ram_in", 32'(ram_in), 32'(cpu_wdata));
      wait_cnt = 0;
    end else if (cpu_req) begin
      wait_cnt++;
    end
    // No raster fetch can be pending outside a frame or once the last word is consumed.
    if (!frame_on || k > 16 * (SW - 1)) begin
      check_eq("cpu_ready_no_raster", 32'(cpu_ready), 32'(cpu_req));
    end else if (cpu_req) begin
      check_eq("cpu_wait_over_1", 32'(wait_cnt > 1), 0);
    end
    accepted = cpu_ready;
    prev_rd  = cpu_ready & ~cpu_we;
    exp_rd   = mem[cpu_addr];
    if (frame_start) begin
      frame_on  = 1'b1;
      k         = 0;
      und_model = 1'b0;
    end else if (pixel_en) begin
      if (starve) begin
        pix_model = 1'b0;
        und_model = 1'b1;
      end else if (frame_on && k < 16 * SW) begin
        w         = mem[k / 16];
        pix_model = w[k % 16];
      end else begin
        pix_model = 1'b0;
      end
      k++;
    end
  endtask

  task automatic cycle();
    @(negedge clk);
    monitor();
    @(posedge clk);
    #1;
  endtask

  // load: percent chance of a new CPU request; 100 means back-to-back reads only.
  task automatic step(input logic fs, input logic pe, input int unsigned load);
    frame_start = fs;
    pixel_en    = pe;
    if (!(cpu_req && !accepted)) begin
      if (load != 0 && $urandom_range(99) < load) begin
        cpu_req   = 1'b1;
        cpu_we    = (load < 100) && ($urandom_range(3) == 0);
        cpu_addr  = cpu_we ? 13'($urandom_range(8191, SW)) : 13'($urandom_range(8191));
        cpu_wdata = 16'($urandom);
      end else begin
        cpu_req = 1'b0;
      end
    end
    cycle();
  endtask

  task automatic run_frame(input int unsigned npix, input int unsigned load);
    int unsigned gap;
    step(1'b1, 1'b0, load);
    gap = 3;
    for (int i = 0; i < int'(npix); i++) begin
      repeat (gap - 1) step(1'b0, 1'b0, load);
      step(1'b0, 1'b1, load);
      gap = $urandom_range(4, 2);
    end
  endtask

  task automatic cpu_op(input logic we, input int unsigned addr, input logic [15:0] data);
    int n;
    n           = 0;
    frame_start = 1'b0;
    pixel_en    = 1'b0;
    cpu_req     = 1'b1;
    cpu_we      = we;
    cpu_addr    = 13'(addr);
    cpu_wdata   = data;
    do begin
      cycle();
      n++;
    end while (!accepted && n < 8);
    check_eq("cpu_op_accepted", 32'(accepted), 1);
    cpu_req = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    n_vec = 0; n_err = 0;
    starve = 1'b0; accepted = 1'b0; prev_rd = 1'b0; frame_on = 1'b0;
    pix_model = 1'b0; und_model = 1'b0; k = 0; wait_cnt = 0;
    exp_rd = 16'h0000; last_rd = 16'h0000;
    reset = 1'b1; cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0;
    frame_start = 1'b0; pixel_en = 1'b0;
    repeat (3) cycle();
    reset = 1'b0;
    step(1'b0, 1'b0, 0);

    // Pixel strobes with no frame ever started stay dark and never underrun.
    repeat (3) begin
      step(1'b0, 1'b1, 0);
      step(1'b0, 1'b0, 0);
    end

    for (int a = 0; a < int'(SW); a++) cpu_op(1'b1, a, 16'($urandom));
    cpu_op(1'b1, 0, 16'h8001);
    cpu_op(1'b1, 1, 16'h00FF);
    cpu_op(1'b1, 5, 16'hAAAA);
    cpu_op(1'b0, 5, 16'h0000);
    step(1'b0, 1'b0, 0);
    check_eq("rdata_addr5", 32'(cpu_rdata), 32'h0000_AAAA);

    // Clean frame, then moderate and saturating CPU load.
    run_frame(16 * SW + 4, 0);
    run_frame(16 * SW + 4, 40);
    run_frame(16 * SW, 100);

    // Pixel strobe right after frame_start starves the buffer.
    step(1'b1, 1'b0, 0);
    starve = 1'b1;
    step(1'b0, 1'b1, 0);
    starve = 1'b0;
    repeat (3) step(1'b0, 1'b0, 0);
    check_eq("underrun_sticky", 32'(underrun), 1);
    check_eq("underrun_pixel", 32'(pixel), 0);
    run_frame(16 * SW + 2, 30);

    // Restart while the fetch of word 4 is in flight.
    run_frame(16 * 3 + 1, 50);
    step(1'b0, 1'b0, 50);
    run_frame(16 * SW + 8, 50);

    // Asynchronous reset in mid-frame, then a fresh frame.
    run_frame(300, 50);
    reset = 1'b1;
    repeat (2) cycle();
    reset = 1'b0;
    run_frame(16 * SW + 4, 30);
    repeat (4) step(1'b0, 1'b0, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
